// File: rtl/pixels_ws2812b_decoder.sv
// Purpose : WS2812B single-wire receiver; decodes high-pulse widths into bits, assembles 24-bit GRB pixels,
//           detects frame end, flags errors and forwards the line once pixel 0 has been captured.
// Latency : 2-FF synchronizer + 1 registered stage; pixel_valid 3 clocks after the final falling edge, bit_out lags bit_in by 3.
// Backpr. : none; the line cannot be stalled, so every output is a pulse or held value.
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset
//   bit_in_i       WS2812B data line (asynchronous)
//   bit_out_o      forwarded line, gated off until pixel 0 of the frame is captured
//   pixel_o        last decoded pixel {G,R,B}, held
//   pixel_valid_o  one-cycle pulse when pixel_o updates
//   pixel_index_o  0-based index of pixel_o within the frame (saturates at 255)
//   frame_done_o   one-cycle pulse at frame end
//   pixel_count_o  full pixels in the frame just ended, valid with frame_done_o
//   error_o        sticky error, cleared by the first rising edge of a new frame
module pixels_ws2812b_decoder #(
    parameter logic [15:0] THRESHOLD_CYCLES = 16'd30,
    parameter logic [15:0] MIN_HIGH_CYCLES  = 16'd5,
    parameter logic [15:0] MAX_HIGH_CYCLES  = 16'd60,
    parameter logic [15:0] RESET_CYCLES     = 16'd2500
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        bit_in_i,
    output logic        bit_out_o,
    output logic [23:0] pixel_o,
    output logic        pixel_valid_o,
    output logic [7:0]  pixel_index_o,
    output logic        frame_done_o,
    output logic [7:0]  pixel_count_o,
    output logic        error_o
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERR} state_t;

    state_t      state_q;
    logic        sync_q, din_q, din_prev_q;
    logic [15:0] hcnt_q, lcnt_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  pix_cnt_q;
    logic [23:0] shift_q;
    logic        fwd_q;
    logic        pend_q;   // rising edge that coincided with frame end, replayed from IDLE
    logic        bit_out_q, pixel_valid_q, frame_done_q, error_q;
    logic [23:0] pixel_q;
    logic [7:0]  pixel_index_q, pixel_count_q;

    logic        rise, fall, bit_val;
    logic [15:0] hcnt_d, lcnt_d;
    logic [23:0] shift_d;

    assign rise    = din_q & ~din_prev_q;
    assign fall    = ~din_q & din_prev_q;
    assign hcnt_d  = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
    assign lcnt_d  = (lcnt_q == 16'hFFFF) ? lcnt_q : lcnt_q + 16'd1;
    assign bit_val = (hcnt_q >= THRESHOLD_CYCLES);
    // First bit of a pixel ends up in bit 23 after 24 shifts.
    assign shift_d = {shift_q[22:0], bit_val};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            sync_q        <= 1'b0;
            din_q         <= 1'b0;
            din_prev_q    <= 1'b0;
            hcnt_q        <= 16'd0;
            lcnt_q        <= 16'd0;
            bit_cnt_q     <= 5'd0;
            pix_cnt_q     <= 8'd0;
            shift_q       <= 24'd0;
            fwd_q         <= 1'b0;
            pend_q        <= 1'b0;
            bit_out_q     <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            pixel_q       <= 24'd0;
            pixel_index_q <= 8'd0;
            pixel_count_q <= 8'd0;
        end else begin
            sync_q        <= bit_in_i;
            din_q         <= sync_q;
            din_prev_q    <= din_q;
            bit_out_q     <= fwd_q & din_q;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    pend_q <= 1'b0;
                    if (rise || (pend_q && din_q)) begin
                        state_q   <= S_HIGH;
                        // A replayed edge has already been high for one extra cycle.
                        hcnt_q    <= pend_q ? 16'd2 : 16'd1;
                        error_q   <= 1'b0;
                        pix_cnt_q <= 8'd0;
                        bit_cnt_q <= 5'd0;
                    end
                end

                S_HIGH: begin
                    if (fall) begin
                        if (hcnt_q < MIN_HIGH_CYCLES) begin
                            error_q <= 1'b1;    // glitch: pulse dropped
                        end else begin
                            shift_q <= shift_d;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q     <= 5'd0;
                                pixel_q       <= shift_d;
                                pixel_valid_q <= 1'b1;
                                pixel_index_q <= pix_cnt_q;
                                if (pix_cnt_q == 8'd0)
                                    fwd_q <= 1'b1;
                                if (pix_cnt_q != 8'hFF)
                                    pix_cnt_q <= pix_cnt_q + 8'd1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                        lcnt_q  <= 16'd1;
                        state_q <= S_LOW;
                    end else if (hcnt_d >= MAX_HIGH_CYCLES) begin
                        error_q <= 1'b1;
                        fwd_q   <= 1'b0;
                        lcnt_q  <= 16'd0;
                        state_q <= S_ERR;
                    end else begin
                        hcnt_q <= hcnt_d;
                    end
                end

                S_LOW: begin
                    // Frame end has priority over a simultaneous rising edge.
                    if (lcnt_d >= RESET_CYCLES) begin
                        frame_done_q  <= 1'b1;
                        pixel_count_q <= pix_cnt_q;
                        if (bit_cnt_q != 5'd0)
                            error_q <= 1'b1;
                        bit_cnt_q <= 5'd0;
                        pix_cnt_q <= 8'd0;
                        fwd_q     <= 1'b0;
                        pend_q    <= rise;
                        state_q   <= S_IDLE;
                    end else if (rise) begin
                        hcnt_q  <= 16'd1;
                        state_q <= S_HIGH;
                    end else begin
                        lcnt_q <= lcnt_d;
                    end
                end

                S_ERR: begin
                    // Wait for an unbroken low of RESET_CYCLES before accepting data again.
                    if (din_q) begin
                        lcnt_q <= 16'd0;
                    end else if (lcnt_d >= RESET_CYCLES) begin
                        state_q <= S_IDLE;
                    end else begin
                        lcnt_q <= lcnt_d;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bit_out_o     = bit_out_q;
    assign pixel_o       = pixel_q;
    assign pixel_valid_o = pixel_valid_q;
    assign pixel_index_o = pixel_index_q;
    assign frame_done_o  = frame_done_q;
    assign pixel_count_o = pixel_count_q;
    assign error_o       = error_q;

endmodule

// File: doc/pixels_ws2812b_decoder.md
# pixels_ws2812b_decoder

Receive-side counterpart of the WS2812B pixel transmitter. It samples a single-wire WS2812B NRZ stream and decodes high-pulse widths into bits. Bits are assembled MSB-first into 24-bit GRB pixels and reported one pixel at a time, with frame-end detection, error flagging, and LED-style forwarding of downstream bits. It is used as an on-board loopback checker for the transmitter and as the input stage of a WS2812B strip monitor.

## Interface
- THRESHOLD_CYCLES, 16'd30: high pulse ≥ this length decodes as 1, otherwise 0 (0.6 µs at 50 MHz).
- MIN_HIGH_CYCLES, 16'd5: high pulse shorter than this is a glitch.
- MAX_HIGH_CYCLES, 16'd60: high pulse reaching this length is a stuck-high error.
- RESET_CYCLES, 16'd2500: low time that ends a frame (50 µs at 50 MHz).
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bit_in  in  1  WS2812B data line, asynchronous to clock.
- bit_out  out  1  forwarded stream: 0 until pixel 0 is captured, then follows the synchronized bit_in.
- pixel  out  24  last decoded pixel {G,R,B}, held until the next pixel.
- pixel_valid  out  1  one-cycle pulse when `pixel` updates.
- pixel_index  out  8  index of `pixel` within the frame, 0-based.
- frame_done  out  1  one-cycle pulse at frame end.
- pixel_count  out  8  full pixels in the frame just ended, valid with frame_done.
- error  out  1  sticky error flag.

## Operation
- Parameter constraint: MIN_HIGH < THRESHOLD < MAX_HIGH < RESET_CYCLES ≤ 65535.
- Input path: bit_in passes through a 2-FF synchronizer, giving din_s. Edge detection compares din_s with its previous value.
- Counters:
  - hcnt and lcnt are 16-bit counters that saturate at all-ones.
  - bit_cnt is 5 bits (0..23).
  - pix_cnt is 8 bits and saturates at 255. Further pixels are still reported with pixel_index = 255.
- States: IDLE, HIGH, LOW, ERR.
- IDLE (entered after reset):
  - On din_s rising: go to HIGH, set hcnt=1, clear error, clear pix_cnt and bit_cnt.
- HIGH:
  - Each cycle, hcnt++.
  - If hcnt reaches MAX_HIGH_CYCLES: set error and go to ERR.
  - On din_s falling with hcnt < MIN_HIGH_CYCLES: set error, discard the pulse, go to LOW, set lcnt=1.
  - On any other din_s falling: bit = (hcnt ≥ THRESHOLD_CYCLES). Shift the bit into the shift register LSB, with the first bit ending at pixel[23]. Set bit_cnt++ and lcnt=1, then go to LOW.
  - When bit_cnt wraps from 23 to 0: load `pixel`, pulse pixel_valid, drive pixel_index = pix_cnt, then pix_cnt++.
- LOW:
  - Each cycle, lcnt++.
  - On din_s rising: go to HIGH with hcnt=1. Error and counters are not cleared.
  - If lcnt reaches RESET_CYCLES: pulse frame_done with pixel_count = pix_cnt. If bit_cnt ≠ 0 (partial pixel), set error. Clear bit_cnt, pix_cnt and the forwarding enable, then go to IDLE.
- ERR:
  - Ignore data.
  - Leave only after din_s has been continuously low for RESET_CYCLES, then go to IDLE.
  - frame_done is not pulsed on this exit.
- Forwarding:
  - fwd_en sets in the cycle pixel 0's pixel_valid pulses and clears at frame end, on ERR entry, or on reset.
  - bit_out = fwd_en & din_s (registered).
- Reset values:
  - bit_out, pixel_valid, frame_done, error: 0.
  - pixel: 24'h000000.
  - pixel_index, pixel_count: 0.
  - State: IDLE; all counters 0.
  - Reset mid-pixel discards partial bits.

## Timing
- Synchronizer latency: 2 clocks.
- pixel_valid is registered and asserts on the 3rd rising edge after bit_in falls at the end of the 24th bit.
- frame_done asserts RESET_CYCLES+2 clocks after the last falling edge on bit_in.
- Nominal transmitter timing at 50 MHz: T0H = 20, T1H = 40, bit period ≈ 62 clocks. Pixel rate is one pixel per ≈ 1500 clocks.
- bit_out lags bit_in by 3 clocks; pulse widths are preserved.
- A rising edge in the same cycle lcnt reaches RESET_CYCLES: frame end wins. The rising edge is taken from IDLE on the next cycle, so it is not lost.

## Test plan
- Three-pixel frame: send 00FF00, FF0000, 0000FF with T0H=20, T1H=40, period 62, then 3000 low. Require:
  - pixel_valid ×3 with (index, pixel) = (0, 00FF00), (1, FF0000), (2, 0000FF).
  - One frame_done with pixel_count = 3, error = 0.
- Threshold boundary: send 24 bits alternating high 29 and high 30 clocks, starting with 29. Require pixel = 555555.
- Glitch and stuck-high:
  - A 3-clock high pulse mid-pixel gives error = 1, with bits before and after still shifting.
  - A 61-clock high pulse gives error = 1 and ERR state, with no pixel_valid or frame_done until 2500 low. A following clean pixel then decodes with error cleared.
- Partial frame: send 12 bits then 3000 low. Require frame_done with pixel_count = 0 and error = 1.
- Forwarding: send a 2-pixel frame. Require bit_out = 0 throughout pixel 0, then bit_out equals bit_in delayed 3 clocks for pixel 1, and 0 after frame_done.
- Reset mid-operation: assert reset at bit 10 of pixel 1. Require all outputs to return to reset values, and the next frame to report pixel_index 0 with correct data.
